// File: rtl/timer_pkg.sv
// Shared types and helpers for the microwave cooking-time controller.
// Contents:
//   state_e      - controller state encoding (IDLE, SET, RUN, PAUSE, DONE)
//   bcd_t        - one BCD digit
//   mmss_t       - four-digit MM:SS time, most significant digit first
//   time_is_zero - 00:00 test
//   bcd_dec      - single-digit BCD decrement with borrow out
//   time_dec     - full MM:SS decrement built from bcd_dec
package timer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSet   = 3'd1,
        StRun   = 3'd2,
        StPause = 3'd3,
        StDone  = 3'd4
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_o;
        bcd_t sec_t;
        bcd_t sec_o;
    } mmss_t;

    localparam mmss_t TimeZero = '0;

    function automatic logic time_is_zero(input mmss_t t);
        return (t == TimeZero);
    endfunction

    // Returns {borrow, digit}. A zero digit borrows and reloads with 'wrap'.
    function automatic logic [4:0] bcd_dec(input bcd_t d, input bcd_t wrap);
        if (d == 4'd0) begin
            return {1'b1, wrap};
        end
        return {1'b0, d - 4'd1};
    endfunction

    // Seconds digits wrap to 59, minutes to 9; entry is not normalised, so a
    // seconds-tens digit above 5 simply counts down through its own value.
    function automatic mmss_t time_dec(input mmss_t t);
        mmss_t      r;
        logic [4:0] s;
        r = t;
        s = bcd_dec(t.sec_o, 4'd9);
        r.sec_o = s[3:0];
        if (s[4]) begin
            s = bcd_dec(t.sec_t, 4'd5);
            r.sec_t = s[3:0];
            if (s[4]) begin
                s = bcd_dec(t.min_o, 4'd9);
                r.min_o = s[3:0];
                if (s[4]) begin
                    s = bcd_dec(t.min_t, 4'd0);
                    r.min_t = s[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler for the cooking timer.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   clr   - synchronous clear, overrides en
//   en    - count enable; the counter holds while low
//   tick  - one-cycle pulse on the last cycle of every CLK_HZ-cycle period
module tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLK_HZ);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = en && (cnt_q == CntMax);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/timer_countdown.sv
// Microwave cooking-time controller: accumulates MM:SS from keypad digits,
// counts down once per second while the door is closed, and drives heat.
// Optional feature macro: TIMER_BEEP_EN (adds BEEP_S parameter and a beep
// counter; without it beep is tied low).
// Ports:
//   clk, rst_n               - clock, synchronous active-low reset
//   key_valid, key_digit     - one-cycle BCD key pulse (digits > 9 ignored)
//   start_p, stop_p          - one-cycle start/resume and stop/clear pulses
//   door_closed              - door level, 1 = shut
//   min_t, min_o, sec_t, sec_o - registered BCD time digits
//   heat                     - magnetron enable, high exactly in RUN
//   done_p                   - one-cycle completion pulse
//   beep                     - buzzer enable
//   state_o                  - current state encoding
module timer_countdown
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned QUICK_S = 30
`ifdef TIMER_BEEP_EN
    ,
    parameter int unsigned BEEP_S  = 3
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start_p,
    input  logic       stop_p,
    input  logic       door_closed,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       heat,
    output logic       done_p,
    output logic       beep,
    output logic [2:0] state_o
);

    localparam mmss_t TimeQuick = {8'h00, 4'(QUICK_S / 10), 4'(QUICK_S % 10)};

    state_e state_q, state_d;
    mmss_t  time_q, time_d;
    logic   done_q, done_d;
    logic   heat_q;
    logic   tick;
    logic   presc_en;
    logic   key_ok;
    mmss_t  shifted;

    assign key_ok  = key_valid && (key_digit <= 4'd9);
    assign shifted = {time_q.min_o, time_q.sec_t, time_q.sec_o, key_digit};

`ifdef TIMER_BEEP_EN
    localparam int unsigned BeepW = $clog2(BEEP_S + 1);

    logic [BeepW-1:0] beep_cnt_q, beep_cnt_d;
    logic             beep_q, beep_d;

    // Prescaler keeps running in DONE so the beep can be timed in seconds.
    assign presc_en = (state_q == StRun) || ((state_q == StDone) && beep_q);

    always_comb begin
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q;
        if (state_d != StDone) begin
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end else if (state_q != StDone) begin
            beep_d     = 1'b1;
            beep_cnt_d = BeepW'(BEEP_S);
        end else if (tick && beep_q) begin
            beep_cnt_d = beep_cnt_q - BeepW'(1);
            if (beep_cnt_q == BeepW'(1)) begin
                beep_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign beep = beep_q;
`else
    assign presc_en = (state_q == StRun);
    assign beep     = 1'b0;
`endif

    // Held clear whenever it is not counting, so every RUN entry starts at 0.
    tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!presc_en),
        .en   (presc_en),
        .tick (tick)
    );

    // Next-state logic; priority stop > door open > start > tick > key.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!stop_p) begin
                    if (start_p) begin
                        if (door_closed && time_is_zero(time_q)) begin
                            time_d  = TimeQuick;
                            state_d = StRun;
                        end
                    end else if (key_ok) begin
                        time_d  = shifted;
                        state_d = StSet;
                    end
                end
            end
            StSet: begin
                if (stop_p) begin
                    time_d  = TimeZero;
                    state_d = StIdle;
                end else if (start_p) begin
                    if (door_closed && !time_is_zero(time_q)) begin
                        state_d = StRun;
                    end
                end else if (key_ok) begin
                    time_d = shifted;
                end
            end
            StRun: begin
                if (stop_p || !door_closed) begin
                    state_d = StPause;
                end else if (tick) begin
                    time_d = time_dec(time_q);
                    if (time_is_zero(time_d)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StPause: begin
                if (stop_p) begin
                    time_d  = TimeZero;
                    state_d = StIdle;
                end else if (start_p && door_closed) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                if (stop_p) begin
                    time_d  = TimeZero;
                    state_d = StIdle;
                end else if (!start_p && key_ok) begin
                    time_d  = {12'h000, key_digit};
                    state_d = StSet;
                end
            end
            default: begin
                time_d  = TimeZero;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            time_q  <= TimeZero;
            done_q  <= 1'b0;
            heat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            done_q  <= done_d;
            heat_q  <= (state_d == StRun);
        end
    end

    assign min_t   = time_q.min_t;
    assign min_o   = time_q.min_o;
    assign sec_t   = time_q.sec_t;
    assign sec_o   = time_q.sec_o;
    assign heat    = heat_q;
    assign done_p  = done_q;
    assign state_o = state_q;

endmodule
